// File: rtl/upbus_pkg.sv
// Shared types and helpers for the microprocessor register bus sequencer.
// Optional slave timeout is enabled by defining UPBUS_TOUT_EN.
package upbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } upbus_state_e;

  localparam logic [7:0] UPBUS_ACT_ADDR = 8'hFF;
  localparam int         UPBUS_DW       = 32;

  // Bits needed to index n items; never less than one.
  function automatic int upbus_clog2(input int n);
    int w;
    w = 1;
    while (int'(32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/upbus_tmr.sv
// Slave-response watchdog: clear/enable counter that saturates at TOUT.
// Only instantiated when UPBUS_TOUT_EN is defined.
module upbus_tmr
  import upbus_pkg::*;
#(
  parameter int TOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = upbus_clog2(TOUT + 1);

  logic [TW-1:0] cnt_r;

  assign expired = (cnt_r == TW'(TOUT));

  // Wait-cycle counter; holds at TOUT so expiry stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {TW{1'b0}};
    end else if (clr) begin
      cnt_r <= {TW{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/upbus_ctrl.sv
// Host-side sequencer: turns one host access into a single-cycle upen pulse and collects upack.
// Define UPBUS_TOUT_EN to add the dead-slave timeout and error reporting for unmapped addresses.
module upbus_ctrl
  import upbus_pkg::*;
#(
  parameter int NSLV = 8,
  parameter int AW   = 8,
  parameter int DW   = UPBUS_DW,
`ifdef UPBUS_TOUT_EN
  parameter int TOUT = 15,
`endif
  parameter logic [AW-1:0] ACT_ADDR = AW'(UPBUS_ACT_ADDR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hcs,
  input  logic                 hwnr,
  input  logic [AW-1:0]        haddr,
  input  logic [DW-1:0]        hwdata,
  output logic                 hack,
  output logic [DW-1:0]        hrdata,
  output logic                 herr,
  output logic                 upact,
  output logic [NSLV-1:0]      upen,
  output logic                 upws,
  output logic                 uprs,
  output logic [DW-1:0]        updi,
  input  logic [NSLV*DW-1:0]   updo_bus,
  input  logic [NSLV-1:0]      upack_bus
);

  localparam int IW = upbus_clog2(NSLV);

  upbus_state_e    state_r, state_s;
  logic [IW-1:0]   sel_r, sel_s;
  logic            wr_r, wr_s;
  logic [NSLV-1:0] upen_r, upen_s;
  logic            upws_r, upws_s;
  logic            uprs_r, uprs_s;
  logic [DW-1:0]   updi_r, updi_s;
  logic            hack_r, hack_s;
  logic [DW-1:0]   hrdata_r, hrdata_s;
  logic            herr_r, herr_s;
  logic            upact_r, upact_s;

`ifdef UPBUS_TOUT_EN
  logic tmr_clr_s;
  logic tmr_en_s;
  logic tmr_exp_s;

  upbus_tmr #(
    .TOUT (TOUT)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_exp_s)
  );
`endif

  assign hack   = hack_r;
  assign hrdata = hrdata_r;
  assign herr   = herr_r;
  assign upact  = upact_r;
  assign upen   = upen_r;
  assign upws   = upws_r;
  assign uprs   = uprs_r;
  assign updi   = updi_r;

  // Next-state and next-output decode; strobes and hack default low so every pulse is one cycle.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    wr_s     = wr_r;
    upen_s   = {NSLV{1'b0}};
    upws_s   = 1'b0;
    uprs_s   = 1'b0;
    updi_s   = {DW{1'b0}};
    hack_s   = 1'b0;
    hrdata_s = {DW{1'b0}};
    herr_s   = 1'b0;
    upact_s  = upact_r;
`ifdef UPBUS_TOUT_EN
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (hcs) begin
          if (haddr < AW'(NSLV)) begin
            state_s = ST_REQ;
            sel_s   = haddr[IW-1:0];
            wr_s    = hwnr;
            upen_s  = {{(NSLV-1){1'b0}}, 1'b1} << haddr[IW-1:0];
            upws_s  = hwnr;
            uprs_s  = ~hwnr;
            updi_s  = hwdata;
          end else if (haddr == ACT_ADDR) begin
            state_s = ST_DONE;
            hack_s  = 1'b1;
            if (hwnr) begin
              upact_s = hwdata[0];
            end else begin
              hrdata_s = {{(DW-1){1'b0}}, upact_r};
            end
          end else begin
            state_s = ST_DONE;
            hack_s  = 1'b1;
`ifdef UPBUS_TOUT_EN
            herr_s  = 1'b1;
`else
            herr_s  = 1'b0;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        state_s = ST_WAIT;
`ifdef UPBUS_TOUT_EN
        tmr_clr_s = 1'b1;
`endif
      end

      ST_WAIT: begin
`ifdef UPBUS_TOUT_EN
        tmr_en_s = 1'b1;
`endif
        // Only the addressed slave may complete the access.
        if (upack_bus[sel_r]) begin
          state_s = ST_DONE;
          hack_s  = 1'b1;
          if (wr_r) begin
            hrdata_s = {DW{1'b0}};
          end else begin
            hrdata_s = updo_bus[int'(sel_r) * DW +: DW];
          end
        end
`ifdef UPBUS_TOUT_EN
        else if (tmr_exp_s) begin
          state_s = ST_DONE;
          hack_s  = 1'b1;
          herr_s  = 1'b1;
        end
`endif
        else begin
          state_s = ST_WAIT;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access and restores active mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sel_r    <= {IW{1'b0}};
      wr_r     <= 1'b0;
      upen_r   <= {NSLV{1'b0}};
      upws_r   <= 1'b0;
      uprs_r   <= 1'b0;
      updi_r   <= {DW{1'b0}};
      hack_r   <= 1'b0;
      hrdata_r <= {DW{1'b0}};
      herr_r   <= 1'b0;
      upact_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      wr_r     <= wr_s;
      upen_r   <= upen_s;
      upws_r   <= upws_s;
      uprs_r   <= uprs_s;
      updi_r   <= updi_s;
      hack_r   <= hack_s;
      hrdata_r <= hrdata_s;
      herr_r   <= herr_s;
      upact_r  <= upact_s;
    end
  end

endmodule

// File: tb/tb_upbus_ctrl.sv
// Directed self-checking bench for upbus_ctrl; timeout scenario runs when UPBUS_TOUT_EN is defined.
module tb_upbus_ctrl;

  localparam int NSLV = 8;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TOUT = 15;

  logic                clk;
  logic                rst_n;
  logic                hcs;
  logic                hwnr;
  logic [AW-1:0]       haddr;
  logic [DW-1:0]       hwdata;
  logic                hack;
  logic [DW-1:0]       hrdata;
  logic                herr;
  logic                upact;
  logic [NSLV-1:0]     upen;
  logic                upws;
  logic                uprs;
  logic [DW-1:0]       updi;
  logic [NSLV*DW-1:0]  updo_bus;
  logic [NSLV-1:0]     upack_bus;

  int checks;
  int errors;

  upbus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcs       (hcs),
    .hwnr      (hwnr),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hack      (hack),
    .hrdata    (hrdata),
    .herr      (herr),
    .upact     (upact),
    .upen      (upen),
    .upws      (upws),
    .uprs      (uprs),
    .updi      (updi),
    .updo_bus  (updo_bus),
    .upack_bus (upack_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hcs    = 1'b1;
    hwnr   = wr;
    haddr  = a;
    hwdata = d;
  endtask

  task automatic stop();
    hcs    = 1'b0;
    hwnr   = 1'b0;
    haddr  = 8'h00;
    hwdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL rst_hack got %b exp 0", hack); end
    checks++; if (upen !== 8'h00) begin errors++; $display("FAIL rst_upen got %h exp 00", upen); end
    checks++; if (upact !== 1'b1) begin errors++; $display("FAIL rst_upact got %b exp 1", upact); end
    checks++; if ({upws, uprs, herr} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {upws, uprs, herr}); end
    checks++; if (hrdata !== 32'h0 || updi !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h exp 0/0", hrdata, updi); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_slave2();
    start(1'b1, 8'h02, 32'h5);
    tick();
    checks++; if (upen !== 8'h04) begin errors++; $display("FAIL wr2_upen got %h exp 04", upen); end
    checks++; if (upws !== 1'b1 || uprs !== 1'b0) begin errors++; $display("FAIL wr2_strobe got ws%b rs%b exp ws1 rs0", upws, uprs); end
    checks++; if (updi !== 32'h5) begin errors++; $display("FAIL wr2_updi got %h exp 5", updi); end
    tick();
    checks++; if (upen !== 8'h00 || upws !== 1'b0) begin errors++; $display("FAIL wr2_pulse1 got %h/%b exp 00/0", upen, upws); end
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL wr2_early got %b exp 0", hack); end
    upack_bus = 8'h04;
    tick();
    checks++; if (hack !== 1'b1 || herr !== 1'b0) begin errors++; $display("FAIL wr2_hack got %b/%b exp 1/0", hack, herr); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL wr2_hrdata got %h exp 0", hrdata); end
    upack_bus = 8'h00;
    stop();
    tick();
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL wr2_hack1 got %b exp 0", hack); end
  endtask

  task automatic test_back_to_back();
    updo_bus[7*DW +: DW] = 32'hDEADBEEF;
    start(1'b0, 8'h07, 32'h0);
    tick();
    checks++; if (upen !== 8'h80 || uprs !== 1'b1 || upws !== 1'b0) begin errors++; $display("FAIL rd7_req got %h rs%b ws%b exp 80 rs1 ws0", upen, uprs, upws); end
    tick();
    checks++; if (uprs !== 1'b0 || upen !== 8'h00) begin errors++; $display("FAIL rd7_wait got rs%b %h exp rs0 00", uprs, upen); end
    upack_bus = 8'h80;
    tick();
    checks++; if (hack !== 1'b1 || hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd7_data got %b/%h exp 1/deadbeef", hack, hrdata); end
    upack_bus = 8'h00;
    stop();
    tick();
    checks++; if (hrdata !== 32'h0 || hack !== 1'b0) begin errors++; $display("FAIL rd7_clear got %h/%b exp 0/0", hrdata, hack); end
  endtask

  task automatic test_act_reg();
    start(1'b1, 8'hFF, 32'h0);
    tick();
    checks++; if (hack !== 1'b1 || upen !== 8'h00) begin errors++; $display("FAIL actw_hack got %b/%h exp 1/00", hack, upen); end
    stop();
    tick();
    checks++; if (upact !== 1'b0 || hack !== 1'b0) begin errors++; $display("FAIL actw_upact got %b/%b exp 0/0", upact, hack); end
    start(1'b0, 8'hFF, 32'h0);
    tick();
    checks++; if (hack !== 1'b1 || hrdata !== 32'h0 || herr !== 1'b0) begin errors++; $display("FAIL actr0 got %b/%h/%b exp 1/0/0", hack, hrdata, herr); end
    checks++; if (upen !== 8'h00 || uprs !== 1'b0) begin errors++; $display("FAIL actr_noen got %h/%b exp 00/0", upen, uprs); end
    stop();
    tick();
    start(1'b1, 8'hFF, 32'h3);
    tick();
    stop();
    tick();
    checks++; if (upact !== 1'b1) begin errors++; $display("FAIL actw1 got %b exp 1", upact); end
    start(1'b0, 8'hFF, 32'h0);
    tick();
    checks++; if (hrdata !== 32'h1) begin errors++; $display("FAIL actr1 got %h exp 1", hrdata); end
    stop();
    tick();
  endtask

  task automatic test_spurious_ack();
    updo_bus[3*DW +: DW] = 32'h12345678;
    updo_bus[1*DW +: DW] = 32'hBADBAD00;
    start(1'b0, 8'h03, 32'h0);
    tick();
    checks++; if (upen !== 8'h08) begin errors++; $display("FAIL sp_upen got %h exp 08", upen); end
    tick();
    upack_bus = 8'h02;
    tick();
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL sp_ignored got %b exp 0", hack); end
    upack_bus = 8'h08;
    tick();
    checks++; if (hack !== 1'b1 || hrdata !== 32'h12345678) begin errors++; $display("FAIL sp_done got %b/%h exp 1/12345678", hack, hrdata); end
    upack_bus = 8'h00;
    stop();
    tick();
  endtask

  task automatic test_unmapped();
    start(1'b0, 8'h10, 32'h0);
    tick();
    checks++; if (hack !== 1'b1 || hrdata !== 32'h0 || upen !== 8'h00) begin errors++; $display("FAIL um_hack got %b/%h/%h exp 1/0/00", hack, hrdata, upen); end
`ifdef UPBUS_TOUT_EN
    checks++; if (herr !== 1'b1) begin errors++; $display("FAIL um_herr got %b exp 1", herr); end
`else
    checks++; if (herr !== 1'b0) begin errors++; $display("FAIL um_herr got %b exp 0", herr); end
`endif
    stop();
    tick();
    checks++; if (herr !== 1'b0 || hack !== 1'b0) begin errors++; $display("FAIL um_clear got %b/%b exp 0/0", herr, hack); end
  endtask

  task automatic test_reset_mid_access();
    start(1'b1, 8'hFF, 32'h0);
    tick();
    stop();
    tick();
    start(1'b0, 8'h05, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    stop();
    tick();
    checks++; if (hack !== 1'b0 || upen !== 8'h00) begin errors++; $display("FAIL rm_abort got %b/%h exp 0/00", hack, upen); end
    checks++; if (upact !== 1'b1) begin errors++; $display("FAIL rm_upact got %b exp 1", upact); end
    rst_n = 1'b1;
    upack_bus = 8'h20;
    tick();
    upack_bus = 8'h00;
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL rm_nohack got %b exp 0", hack); end
    start(1'b1, 8'h00, 32'hA5);
    tick();
    checks++; if (upen !== 8'h01 || updi !== 32'hA5) begin errors++; $display("FAIL rm_s0req got %h/%h exp 01/a5", upen, updi); end
    tick();
    upack_bus = 8'h01;
    tick();
    checks++; if (hack !== 1'b1 || herr !== 1'b0) begin errors++; $display("FAIL rm_s0done got %b/%b exp 1/0", hack, herr); end
    upack_bus = 8'h00;
    stop();
    tick();
  endtask

`ifdef UPBUS_TOUT_EN
  task automatic test_timeout();
    bit early;
    early = 1'b0;
    start(1'b1, 8'h04, 32'h7);
    tick();
    tick();
    for (int i = 0; i < TOUT; i++) begin
      tick();
      if (hack !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early got 1 exp 0"); end
    tick();
    checks++; if (hack !== 1'b1 || herr !== 1'b1 || hrdata !== 32'h0) begin errors++; $display("FAIL to_expire got %b/%b/%h exp 1/1/0", hack, herr, hrdata); end
    stop();
    tick();
    upack_bus = 8'h10;
    tick();
    upack_bus = 8'h00;
    checks++; if (hack !== 1'b0) begin errors++; $display("FAIL to_late got %b exp 0", hack); end
    tick();
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    hcs       = 1'b0;
    hwnr      = 1'b0;
    haddr     = 8'h00;
    hwdata    = 32'h0;
    updo_bus  = '0;
    upack_bus = 8'h00;
    test_reset();
    test_write_slave2();
    test_back_to_back();
    test_act_reg();
    test_spurious_ack();
    test_unmapped();
    test_reset_mid_access();
`ifdef UPBUS_TOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
